// File: rtl/ad_sample_stream_sched.sv
// Round-robin scheduler: NUM_CH FWFT sample FIFOs -> one AXI-Stream master with a 1-deep output register.
// Optional SCHED_PKT_LOCK_EN: hold the grant until the popped word carries EOP (no packet interleaving).
module ad_sample_stream_sched #(
  parameter  int NUM_CH    = 4,
  parameter  int DATA_W    = 8,
  parameter  int BURST_LEN = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*(DATA_W+1)-1:0] fifo_data,
  input  logic [NUM_CH-1:0]            fifo_empty,
  output logic [NUM_CH-1:0]            fifo_rd,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tvalid,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic                         m_axis_tlast,
  output logic [CH_W-1:0]              m_axis_tuser,
  output logic                         busy,
  output logic [CH_W-1:0]              grant_ch
);

  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [BW-1:0]     beat_q, beat_d, beat_inc;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [CH_W-1:0]   tuser_q, tuser_d;

  logic [DATA_W:0]   words [NUM_CH];
  logic [DATA_W:0]   gword;
  logic [NUM_CH-1:0] elig;
  logic [CH_W-1:0]   pick;
  logic [CH_W:0]     cand;
  logic              found, slot_free, pop, release_g;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_word
    assign words[g] = fifo_data[g*(DATA_W+1) +: DATA_W+1];
  end

  assign elig      = ch_en & ~fifo_empty;
  assign gword     = words[grant_q];
  assign slot_free = !tvalid_q | m_axis_tready;
  assign beat_inc  = beat_q + 1'b1;

  // First eligible channel after the last grant, wrapping modulo NUM_CH.
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = {1'b0, rr_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(NUM_CH)) cand = cand - (CH_W+1)'(NUM_CH);
      if (!found && elig[cand[CH_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    beat_d    = beat_q;
    fifo_rd   = '0;
    pop       = 1'b0;
    release_g = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && found) begin
          state_d = XFER;
          grant_d = pick;
          rr_d    = pick;
          beat_d  = '0;
        end
      end
      XFER: begin
        pop              = slot_free & !fifo_empty[grant_q];
        fifo_rd[grant_q] = pop;
        if (pop && beat_q != BW'(BURST_LEN)) beat_d = beat_inc;
`ifdef SCHED_PKT_LOCK_EN
        release_g = pop & gword[DATA_W];
`else
        release_g = (pop & (gword[DATA_W] | (beat_inc == BW'(BURST_LEN))))
                  | (fifo_empty[grant_q] & slot_free);
`endif
        if (release_g) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register loads only on a pop; it drains on handshake regardless of FSM state.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (pop) begin
      tvalid_d = 1'b1;
      tdata_d  = gword[DATA_W-1:0];
      tlast_d  = gword[DATA_W];
      tuser_d  = grant_q;
    end else if (slot_free) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= CH_W'(NUM_CH - 1);
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign busy          = (state_q == XFER);
  assign grant_ch      = grant_q;

endmodule

// File: tb/tb_ad_sample_stream_sched.sv
// Scoreboard bench for ad_sample_stream_sched: FIFO models feed the DUT, a negedge monitor checks the stream.
// Expectations adapt to SCHED_PKT_LOCK_EN when that macro is defined for the build.
module tb_ad_sample_stream_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  ch_en;
  logic [35:0] fifo_data;
  logic [3:0]  fifo_empty;
  logic [3:0]  fifo_rd;
  logic        tready;
  logic        tvalid;
  logic [7:0]  tdata;
  logic        tlast;
  logic [1:0]  tuser;
  logic        busy;
  logic [1:0]  grant_ch;

  ad_sample_stream_sched #(.NUM_CH(4), .DATA_W(8), .BURST_LEN(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_en(ch_en),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .m_axis_tready(tready), .m_axis_tvalid(tvalid), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser), .busy(busy), .grant_ch(grant_ch)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [8:0]  fq [4][$];
  logic [10:0] exp_q [$];
  int          hs_cyc [$];
  int          popcnt [4];
  bit          tr_toggle = 0;
  bit          prev_stall = 0;
  logic [10:0] prev_word;

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic logic [10:0] ew(input int d, input bit l, input int u);
    return {d[7:0], l, u[1:0]};
  endfunction

  task automatic refresh();
    for (int c = 0; c < 4; c++) begin
      fifo_empty[c] = (fq[c].size() == 0);
      fifo_data[c*9 +: 9] = (fq[c].size() > 0) ? fq[c][0] : 9'd0;
    end
  endtask

  // Inputs change 1ns after posedge; pops are those the DUT strobed during the cycle just ended.
  task automatic tick();
    logic [3:0] rd;
    logic [8:0] junk;
    @(negedge clk);
    rd = fifo_rd;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++)
      if (rd[c] && fq[c].size() > 0) begin
        junk = fq[c].pop_front();
        popcnt[c]++;
      end
    if (tr_toggle) tready = ~tready;
    refresh();
  endtask

  task automatic load(input int c, input int base, input int lo, input int hi, input int eop_at);
    logic [7:0] d;
    for (int j = lo; j <= hi; j++) begin
      d = 8'(base + j);
      fq[c].push_back({(j == eop_at), d});
    end
    refresh();
  endtask

  task automatic expect_words(input int c, input int base, input int lo, input int hi, input int eop_at);
    for (int j = lo; j <= hi; j++) exp_q.push_back(ew(base + j, (j == eop_at), c));
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      fq[c].delete();
      popcnt[c] = 0;
    end
    hs_cyc.delete();
    refresh();
    tick();
    rst = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    logic [10:0] e;
    cyc++;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("hold_under_backpressure", {tvalid, tdata, tlast, tuser}, {1'b1, prev_word});
      if (|fifo_rd) begin
        chk("rd_onehot", $onehot(fifo_rd), 1);
        chk("rd_only_when_slot_free", (!tvalid || tready), 1);
      end
      if (tvalid && tready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_word: got %0h, none expected", {tdata, tlast, tuser});
        end else begin
          e = exp_q.pop_front();
          chk("stream_word{data,last,user}", {tdata, tlast, tuser}, e);
        end
      end
      prev_stall = tvalid && !tready;
      prev_word  = {tdata, tlast, tuser};
    end
  end

  initial begin
    bit seen_busy;
    rst = 1'b1; enable = 1'b0; ch_en = '0; tready = 1'b1;
    fifo_data = '0; fifo_empty = '1;
    for (int c = 0; c < 4; c++) popcnt[c] = 0;
    refresh();
    tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_ch, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    rst = 1'b0; enable = 1'b1; ch_en = 4'hF;
    tick();

    // 1: reset mid-stream with a word held in the output register
    tready = 1'b0;
    load(2, 8'h20, 0, 5, 5);
    repeat (3) tick();
    chk("t1_inflight_tvalid", tvalid, 1);
    rst = 1'b1;
    #1;
    chk("t1_rst_fifo_rd", fifo_rd, 0);
    chk("t1_rst_tvalid", tvalid, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_ch2_left", fq[2].size(), 5);
    load(0, 8'h00, 0, 1, 1);
    tready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    expect_words(0, 8'h00, 0, 1, 1);
    expect_words(2, 8'h20, 1, 5, 5);
    tick();
    chk("t1_first_busy", busy, 1);
    chk("t1_first_grant", grant_ch, 0);
    wait_drain("t1", 100);

    // 2: single channel packet
    do_reset();
    load(1, 0, 0, 4, 4);
    expect_words(1, 0, 0, 4, 4);
    wait_drain("t2", 50);
    chk("t2_pops_ch1", popcnt[1], 5);
    chk("t2_handshakes", hs_cyc.size(), 5);
    if (hs_cyc.size() == 5) chk("t2_back_to_back_span", hs_cyc[4] - hs_cyc[0], 4);

    // 3: all channels loaded, bursts of BURST_LEN then remainder, round-robin order
    do_reset();
    for (int c = 0; c < 4; c++)
`ifdef SCHED_PKT_LOCK_EN
      for (int j = 0; j < 20; j++) fq[c].push_back({(j == 15 || j == 19), 8'(c*64 + j)});
`else
      load(c, c*64, 0, 19, -1);
`endif
    refresh();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        for (int j = r*16; j < (r == 0 ? 16 : 20); j++)
`ifdef SCHED_PKT_LOCK_EN
          exp_q.push_back(ew(c*64 + j, (j == 15 || j == 19), c));
`else
          exp_q.push_back(ew(c*64 + j, 1'b0, c));
`endif
    wait_drain("t3", 400);
    chk("t3_ch3_pops", popcnt[3], 20);

    // 4: toggling backpressure
    do_reset();
    tr_toggle = 1;
    load(2, 8'hA0, 0, 7, 7);
    expect_words(2, 8'hA0, 0, 7, 7);
    wait_drain("t4", 100);
    chk("t4_pops_ch2", popcnt[2], 8);
    tr_toggle = 0; tready = 1'b1;

    // 5: channel mask, then enable gating
    do_reset();
    ch_en = 4'b0101;
    load(1, 8'h10, 0, 1, 1);
    load(3, 8'h30, 0, 1, 1);
    for (int j = 0; j < 3; j++) begin
      fq[0].push_back({1'b1, 8'(8'h80 + j)});
      fq[2].push_back({1'b1, 8'(8'h90 + j)});
      exp_q.push_back(ew(8'h80 + j, 1'b1, 0));
      exp_q.push_back(ew(8'h90 + j, 1'b1, 2));
    end
    refresh();
    wait_drain("t5_mask", 100);
    enable = 1'b0; ch_en = 4'hF;
    seen_busy = 0;
    repeat (8) begin
      tick();
      if (busy) seen_busy = 1;
    end
    chk("t5_no_grant_when_disabled", seen_busy, 0);
    expect_words(3, 8'h30, 0, 1, 1);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    chk("t5_grant_busy", busy, 1);
    chk("t5_grant_ch3", grant_ch, 3);
    repeat (12) tick();
    chk("t5_idle_after_grant", busy, 0);
    chk("t5_ch1_untouched", fq[1].size(), 2);
    chk("t5_ch3_drained", fq[3].size(), 0);
    chk("t5_ch3_words_out", exp_q.size(), 0);
    expect_words(1, 8'h10, 0, 1, 1);
    enable = 1'b1;
    wait_drain("t5_resume", 50);

    // 6: granted FIFO runs dry mid-packet while ch1 waits
    do_reset();
    load(0, 8'h60, 0, 2, -1);
    load(1, 8'h70, 0, 1, 1);
    expect_words(0, 8'h60, 0, 2, -1);
`ifndef SCHED_PKT_LOCK_EN
    expect_words(1, 8'h70, 0, 1, 1);
`endif
    repeat (20) tick();
`ifdef SCHED_PKT_LOCK_EN
    chk("t6_lock_busy", busy, 1);
    chk("t6_lock_grant", grant_ch, 0);
    chk("t6_lock_ch1_waits", fq[1].size(), 2);
`else
    chk("t6_released_busy", busy, 0);
    chk("t6_ch1_served", fq[1].size(), 0);
`endif
    chk("t6_first_part_out", exp_q.size(), 0);
    load(0, 8'h60, 3, 5, 5);
    expect_words(0, 8'h60, 3, 5, 5);
`ifdef SCHED_PKT_LOCK_EN
    expect_words(1, 8'h70, 0, 1, 1);
`endif
    wait_drain("t6", 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
